// File: rtl/cordic_pkg.sv
// Shared types and elaboration-time helpers for the iterative CORDIC engine.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // round(atan(2^-i)/pi * 2^n_frac); table holds the value scaled by 2^24.
  function automatic int atan_lut(input int i, input int n_frac);
    int unsigned t;
    case (i)
      0:       t = 32'd4194304;
      1:       t = 32'd2476042;
      2:       t = 32'd1308273;
      3:       t = 32'd664101;
      4:       t = 32'd333339;
      5:       t = 32'd166832;
      6:       t = 32'd83436;
      7:       t = 32'd41721;
      8:       t = 32'd20861;
      default: t = 32'd5340354 >> i;
    endcase
    return int'((t + (32'd1 << (23 - n_frac))) >> (24 - n_frac));
  endfunction

  function automatic int half_pi(input int n_frac);
    return 1 << (n_frac - 1);
  endfunction

  function automatic logic signed [31:0] sat(input logic signed [31:0] v,
                                             input int in_w, input int out_w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (out_w - 1));
    if (in_w <= out_w) return v;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int cnt_width(input int n_iter);
    return (n_iter <= 1) ? 1 : $clog2(n_iter);
  endfunction

  // Shift amount must reach N_FRAC (largest micro-rotation index).
  function automatic int shift_width(input int n_frac);
    return $clog2(n_frac + 2);
  endfunction

endpackage

// File: rtl/cordic_step.sv
// Single combinational CORDIC micro-rotation for rotation or vectoring mode.
module cordic_step
  import cordic_pkg::*;
#(
  parameter int N_FRAC  = 7,
  parameter int N_GUARD = 2
) (
  input  logic signed [N_FRAC+N_GUARD:0]      x,
  input  logic signed [N_FRAC+N_GUARD:0]      y,
  input  logic signed [N_FRAC:0]              z,
  input  logic                                mode,
  input  logic [shift_width(N_FRAC)-1:0]      shift,
  input  logic signed [N_FRAC:0]              angle,
  output logic signed [N_FRAC+N_GUARD:0]      x_next,
  output logic signed [N_FRAC+N_GUARD:0]      y_next,
  output logic signed [N_FRAC:0]              z_next
);

  logic                          d_pos;
  logic signed [N_FRAC+N_GUARD:0] xs;
  logic signed [N_FRAC+N_GUARD:0] ys;

  always_comb begin
    d_pos = mode ? y[N_FRAC+N_GUARD] : ~z[N_FRAC];
    xs    = x >>> shift;
    ys    = y >>> shift;
    if (d_pos) begin
      x_next = x - ys;
      y_next = y + xs;
      z_next = z - angle;
    end else begin
      x_next = x + ys;
      y_next = y - xs;
      z_next = z + angle;
    end
  end

endmodule

// File: rtl/cordic_iterative_mc.sv
// Iterative CORDIC engine: quadrant pre-rotation, N_ITER micro-rotations,
// saturated outputs and valid/ready handshakes on both sides.
module cordic_iterative_mc
  import cordic_pkg::*;
#(
  parameter int N_FRAC  = 7,
  parameter int N_ITER  = 6,
  parameter int N_GUARD = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 mode_i,
  input  logic signed [N_FRAC:0] x_i,
  input  logic signed [N_FRAC:0] y_i,
  input  logic signed [N_FRAC:0] z_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic signed [N_FRAC:0] x_o,
  output logic signed [N_FRAC:0] y_o,
  output logic signed [N_FRAC:0] z_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i
);

  localparam int W  = N_FRAC + 1;
  localparam int XW = W + N_GUARD;
  localparam int CW = cnt_width(N_ITER);
  localparam int SW = shift_width(N_FRAC);

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic                 mode_q;
  logic                 capture;
  logic                 last;
  logic signed [XW-1:0] x_q, y_q, x_ext, y_ext, x_pre, y_pre, x_step, y_step;
  logic signed [W-1:0]  z_q, z_pre, z_step, angle, half;

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign capture     = in_valid_i & in_ready_o;
  assign last        = (cnt_q == CW'(N_ITER - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid_i) state_d = CALC;
      CALC:    if (last) state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Fold the input into the right half-plane so the micro-rotations converge.
  always_comb begin
    x_ext = {{N_GUARD{x_i[W-1]}}, x_i};
    y_ext = {{N_GUARD{y_i[W-1]}}, y_i};
    half  = W'(half_pi(N_FRAC));
    x_pre = x_ext;
    y_pre = y_ext;
    z_pre = z_i;
    if (!mode_i) begin
      if (z_i[W-1:W-2] == 2'b01) begin
        x_pre = -y_ext;
        y_pre = x_ext;
        z_pre = z_i - half;
      end else if (z_i[W-1:W-2] == 2'b10) begin
        x_pre = y_ext;
        y_pre = -x_ext;
        z_pre = z_i + half;
      end
    end else if (x_i[W-1]) begin
      if (!y_i[W-1]) begin
        x_pre = y_ext;
        y_pre = -x_ext;
        z_pre = z_i + half;
      end else begin
        x_pre = -y_ext;
        y_pre = x_ext;
        z_pre = z_i - half;
      end
    end
  end

  assign angle = W'(atan_lut(int'(cnt_q), N_FRAC));

  cordic_step #(
    .N_FRAC  (N_FRAC),
    .N_GUARD (N_GUARD)
  ) u_step (
    .x      (x_q),
    .y      (y_q),
    .z      (z_q),
    .mode   (mode_q),
    .shift  (SW'(cnt_q)),
    .angle  (angle),
    .x_next (x_step),
    .y_next (y_step),
    .z_next (z_step)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        mode_q <= mode_i;
        cnt_q  <= '0;
        x_q    <= x_pre;
        y_q    <= y_pre;
        z_q    <= z_pre;
      end else if (state_q == CALC) begin
        cnt_q <= last ? '0 : cnt_q + 1'b1;
        x_q   <= x_step;
        y_q   <= y_step;
        z_q   <= z_step;
      end
    end
  end

  assign x_o = W'(sat(32'(x_q), XW, W));
  assign y_o = W'(sat(32'(y_q), XW, W));
  assign z_o = z_q;

endmodule

// File: tb/tb_cordic_iterative_mc.sv
// Directed bench for cordic_iterative_mc with hand-computed bit-true results.
module tb_cordic_iterative_mc;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mode;
  logic signed [7:0] x_in, y_in, z_in;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] x_out, y_out, z_out;
  logic              out_valid;
  logic              out_ready;
  int                checks = 0;
  int                errors = 0;
  int                lat;

  always #5 clk = ~clk;

  cordic_iterative_mc #(
    .N_FRAC  (7),
    .N_ITER  (6),
    .N_GUARD (2)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .mode_i      (mode),
    .x_i         (x_in),
    .y_i         (y_in),
    .z_i         (z_in),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .x_o         (x_out),
    .y_o         (y_out),
    .z_o         (z_out),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start(input logic m, input logic signed [7:0] xv,
                       input logic signed [7:0] yv, input logic signed [7:0] zv);
    @(negedge clk);
    mode = m; x_in = xv; y_in = yv; z_in = zv; in_valid = 1'b1;
    chk("in_ready_at_capture", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    chk({tag, "_latency"}, lat, 6);
  endtask

  task automatic check_out(input string tag, input int ex, input int ey, input int ez);
    chk({tag, "_x"}, x_out, ex);
    chk({tag, "_y"}, y_out, ey);
    chk({tag, "_z"}, z_out, ez);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_in_ready_busy"}, in_ready, 0);
  endtask

  task automatic accept(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, "_valid_cleared"}, out_valid, 0);
    chk({tag, "_idle_ready"}, in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; x_in = '0; y_in = '0; z_in = '0;
    in_valid = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_x", x_out, 0);
    chk("rst_y", y_out, 0);
    chk("rst_z", z_out, 0);
    chk("rst_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_release_ready", in_ready, 1);

    start(1'b0, 8'sd64, 8'sd0, 8'sd0);
    wait_done("rot0");
    check_out("rot0", 106, -2, 0);
    accept("rot0");

    start(1'b0, 8'sd50, 8'sd0, 8'sd96);
    wait_done("rot_q1");
    check_out("rot_q1", -60, 59, 0);
    accept("rot_q1");

    start(1'b0, 8'sd50, 8'sd0, -8'sd96);
    wait_done("rot_q2");
    check_out("rot_q2", -59, -56, 0);
    accept("rot_q2");

    start(1'b0, -8'sd128, 8'sd0, 8'sd0);
    wait_done("rot_negsat");
    check_out("rot_negsat", -128, 3, 0);
    accept("rot_negsat");

    start(1'b1, 8'sd32, 8'sd32, 8'sd0);
    wait_done("vec45");
    check_out("vec45", 76, -1, 32);
    accept("vec45");

    start(1'b1, -8'sd40, 8'sd0, 8'sd0);
    wait_done("vec_pi");
    check_out("vec_pi", 66, -1, -128);
    accept("vec_pi");

    start(1'b1, -8'sd32, -8'sd32, 8'sd0);
    wait_done("vec_q3");
    check_out("vec_q3", 76, -1, -96);
    accept("vec_q3");

    // Saturation plus backpressure; the extra in_valid pulse must be dropped.
    start(1'b1, 8'sd127, 8'sd127, 8'sd0);
    wait_done("vec_sat");
    check_out("vec_sat", 127, -2, 32);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        mode = 1'b0; x_in = 8'sd10; y_in = 8'sd0; z_in = 8'sd0; in_valid = 1'b1;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      check_out("hold", 127, -2, 32);
    end
    accept("vec_sat");
    repeat (3) @(posedge clk);
    #1;
    chk("ignored_pulse_valid", out_valid, 0);
    chk("ignored_pulse_ready", in_ready, 1);

    // Asynchronous reset while counter is 3.
    start(1'b0, 8'sd64, 8'sd0, 8'sd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_x", x_out, 0);
    chk("abort_y", y_out, 0);
    chk("abort_z", z_out, 0);
    chk("abort_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1 chk("abort_no_output", out_valid, 0);

    start(1'b0, 8'sd64, 8'sd0, 8'sd0);
    wait_done("after_rst");
    check_out("after_rst", 106, -2, 0);
    accept("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
